inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache that answers the instruction fetcher's `fetch_inst`/`current_PC` request with a combinational hit response (`inst_valid`/`inst_data`). On a miss it refills one full line, word by word, from the memory controller over a request/valid handshake. It sits between the fetcher and the memory controller's instruction port, and it never writes memory.

## Interface
Parameters:
- `INDEX_BITS`, 4: log2 of the number of lines (16 lines).
- `WORD_BITS`, 2: log2 of the number of 32-bit words per line (4 words, 16 B).

Ports (one clock; reset is asynchronous and active-high):
- `clk_in`  in  1  clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  global pause; the block freezes when low.
- `fetch_inst`  in  1  fetcher requests the instruction at `current_PC`.
- `current_PC`  in  32  fetch address; bits [1:0] are ignored.
- `inst_valid`  out  1  hit; `inst_data` holds the word at `current_PC`.
- `inst_data`  out  32  instruction word; 0 when `inst_valid` is low.
- `mem_req`  out  1  refill word request; held until served.
- `mem_addr`  out  32  word-aligned refill address; stable while `mem_req` is high.
- `mem_valid`  in  1  one-cycle pulse; `mem_data` carries the word for `mem_addr`.
- `mem_data`  in  32  refill word.

## Operation
Address split:
- tag = PC[31 : 2+WORD_BITS+INDEX_BITS]
- index = PC[2+WORD_BITS+INDEX_BITS-1 : 2+WORD_BITS]
- word = PC[2+WORD_BITS-1 : 2]

Storage is register-based: `valid[2^INDEX_BITS]`, `tag[2^INDEX_BITS]` and `data[2^INDEX_BITS][2^WORD_BITS]` of 32 bits.

Hit rule:
- `inst_valid = rdy_in && fetch_inst && state==IDLE && valid[index] && tag[index]==tag(PC)`.
- `inst_data = data[index][word]` when `inst_valid` is high, else 0.

FSM states and transitions:
- IDLE:
  - Stays in IDLE while there is no request or the request hits.
  - On `fetch_inst && !hit`: latch `refill_tag` and `refill_idx` from the PC, clear `valid[refill_idx]`, set `cnt=0`, go to REFILL.
- REFILL:
  - Drive `mem_req=1` and `mem_addr={refill_tag, refill_idx, cnt, 2'b00}`.
  - On `mem_valid`: write `data[refill_idx][cnt]=mem_data`, then `cnt++`.
  - On `mem_valid` with `cnt` = last word: set `valid[refill_idx]=1` and `tag[refill_idx]=refill_tag`, drop `mem_req`, go to IDLE.

Other rules:
- The refill always fetches the whole line in order, starting at word 0; there is no critical-word-first.
- If the PC changes mid-refill (branch redirect or ROB reset), the line fill still completes. The next IDLE cycle then looks up the new PC.
- While `rdy_in` is low: no state, counter or array updates, `inst_valid=0`, `mem_req` and `mem_addr` are held. The memory controller does not pulse `mem_valid` while `rdy_in` is low.
- `mem_valid` arriving in IDLE is ignored.

Reset values: state=IDLE, all `valid`=0, `cnt`=0, `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `inst_data`=0. Tag and data arrays are not reset. Reset asserted mid-refill abandons the fill; the line stays invalid.

## Timing
- Hit: zero latency. Response is valid in the same cycle as the request, from registered arrays.
- Miss detected in cycle T: `inst_valid=0` in T; `mem_req=1` from T+1.
- Each word: `mem_req`/`mem_addr` are held until the `mem_valid` cycle. The next address is presented in the following cycle.
- The final `mem_valid` at cycle F sets the line valid at the edge ending F. IDLE and the hit occur in F+1 if the PC is unchanged.
- Miss penalty = 1 + Σ(per-word memory latency). There are no bubbles between words beyond the one cycle for the address update.

## Structure
- Package `inst_cache_pkg`: state enum (IDLE, REFILL), the default `INDEX_BITS`/`WORD_BITS`, and tag/index/word field-extract functions.
- Optional sub-module `inst_cache_array`: valid/tag/data register storage with one write port and one combinational read port. The FSM and hit logic stay in `inst_cache`.

## Test plan
- Cold miss: reset, PC=0x0000_0000, memory returns 0x0000_0013, 0x0010_0093, … with a 3-cycle latency per word.
  - Required: `mem_addr` sequence 0x0, 0x4, 0x8, 0xC.
  - Required: `inst_valid` rises the cycle after the 4th `mem_valid`, with `inst_data`=0x0000_0013.
- Hit stream: after the fill, step PC 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Required: `inst_valid=1` every cycle, correct words, `mem_req=0` throughout.
- Conflict eviction: fill PC=0x0, then fetch PC=0x100 (same index 0, different tag).
  - Required: a refill is issued for 0x100–0x10C.
  - Required: a return to 0x0 misses again.
- Redirect mid-refill: miss at 0x40; after the 2nd word, change PC to 0x0 (resident).
  - Required: the refill completes 0x48 and 0x4C.
  - Required: the next IDLE cycle hits 0x0; the 0x40 line is valid afterward.
- `rdy_in` low for 5 cycles during REFILL.
  - Required: `mem_req` and `mem_addr` are held, `inst_valid=0`, `cnt` is unchanged.
  - Required: the refill resumes correctly.
- Async reset mid-refill: assert `rst_in` between clock edges.
  - Required: `mem_req` drops immediately.
  - Required: the partially filled line is invalid, and the next fetch to it misses.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types and PC field-extract helpers for the instruction cache.
package inst_cache_pkg;

    localparam int unsigned DEF_INDEX_BITS = 32'd4;
    localparam int unsigned DEF_WORD_BITS  = 32'd2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } cache_state_e;

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned ib,
                                           input int unsigned wb);
        return pc >> (32'd2 + wb + ib);
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned ib,
                                             input int unsigned wb);
        return (pc >> (32'd2 + wb)) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_word(input logic [31:0] pc, input int unsigned wb);
        return (pc >> 32'd2) & ((32'd1 << wb) - 32'd1);
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetcher-side request/response and memory-side refill handshake of the cache.
interface inst_cache_if;
    logic        fetch_inst;
    logic [31:0] current_PC;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport slave (
        input  fetch_inst, current_PC, mem_valid, mem_data,
        output inst_valid, inst_data, mem_req, mem_addr
    );

    modport master (
        output fetch_inst, current_PC, mem_valid, mem_data,
        input  inst_valid, inst_data, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache_array.sv
// Register-based valid/tag/data storage: one write port, one combinational read port.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned WORD_BITS  = DEF_WORD_BITS,
    localparam int unsigned TAG_W     = 32'd30 - INDEX_BITS - WORD_BITS,
    localparam int unsigned LINES     = 32'd1 << INDEX_BITS,
    localparam int unsigned WORDS     = 32'd1 << WORD_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  inv_we_s,
    input  logic                  tag_we_s,
    input  logic                  data_we_s,
    input  logic [INDEX_BITS-1:0] wr_idx_s,
    input  logic [WORD_BITS-1:0]  wr_word_s,
    input  logic [TAG_W-1:0]      wr_tag_s,
    input  logic [31:0]           wr_data_s,
    input  logic [INDEX_BITS-1:0] rd_idx_s,
    input  logic [WORD_BITS-1:0]  rd_word_s,
    output logic                  rd_valid_s,
    output logic [TAG_W-1:0]      rd_tag_s,
    output logic [31:0]           rd_data_s
);
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES][WORDS];

    // Valid bits: the only storage cleared by reset; invalidate wins over set.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r <= {LINES{1'b0}};
        end else if (inv_we_s) begin
            valid_r[wr_idx_s] <= 1'b0;
        end else if (tag_we_s) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data payload, deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (tag_we_s) begin
            tag_r[wr_idx_s] <= wr_tag_s;
        end
        if (data_we_s) begin
            data_r[wr_idx_s][wr_word_s] <= wr_data_s;
        end
    end

    assign rd_valid_s = valid_r[rd_idx_s];
    assign rd_tag_s   = tag_r[rd_idx_s];
    assign rd_data_s  = data_r[rd_idx_s][rd_word_s];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hit path plus an
// in-order whole-line refill FSM toward the memory controller.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned WORD_BITS  = DEF_WORD_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    inst_cache_if.slave bus
);
    localparam int unsigned TAG_W = 32'd30 - INDEX_BITS - WORD_BITS;
    localparam logic [WORD_BITS-1:0] LAST_WORD = {WORD_BITS{1'b1}};

    logic [31:0]           tag_full_s, idx_full_s, word_full_s;
    logic [TAG_W-1:0]      pc_tag_s;
    logic [INDEX_BITS-1:0] pc_idx_s;
    logic [WORD_BITS-1:0]  pc_word_s;

    cache_state_e          state_r, state_nxt_s;
    logic [WORD_BITS-1:0]  cnt_r;
    logic [TAG_W-1:0]      refill_tag_r;
    logic [INDEX_BITS-1:0] refill_idx_r;
    logic                  mem_req_r;
    logic [31:0]           mem_addr_r;

    logic                  hit_s, miss_s, fill_word_s, fill_last_s;
    logic                  rd_valid_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [31:0]           rd_data_s;
    logic [INDEX_BITS-1:0] wr_idx_s;

    assign tag_full_s  = pc_tag(bus.current_PC, INDEX_BITS, WORD_BITS);
    assign idx_full_s  = pc_index(bus.current_PC, INDEX_BITS, WORD_BITS);
    assign word_full_s = pc_word(bus.current_PC, WORD_BITS);
    assign pc_tag_s    = tag_full_s[TAG_W-1:0];
    assign pc_idx_s    = idx_full_s[INDEX_BITS-1:0];
    assign pc_word_s   = word_full_s[WORD_BITS-1:0];

    // A miss invalidates the requested line; every other write targets the line being filled.
    assign wr_idx_s = miss_s ? pc_idx_s : refill_idx_r;

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inv_we_s   (miss_s),
        .tag_we_s   (fill_last_s),
        .data_we_s  (fill_word_s),
        .wr_idx_s   (wr_idx_s),
        .wr_word_s  (cnt_r),
        .wr_tag_s   (refill_tag_r),
        .wr_data_s  (bus.mem_data),
        .rd_idx_s   (pc_idx_s),
        .rd_word_s  (pc_word_s),
        .rd_valid_s (rd_valid_s),
        .rd_tag_s   (rd_tag_s),
        .rd_data_s  (rd_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else if (rdy_in) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state and hit/miss/fill decode; everything is gated by rdy_in.
    always_comb begin
        state_nxt_s = state_r;
        hit_s       = 1'b0;
        miss_s      = 1'b0;
        fill_word_s = 1'b0;
        fill_last_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rdy_in && bus.fetch_inst) begin
                    if (rd_valid_s && (rd_tag_s == pc_tag_s)) begin
                        hit_s = 1'b1;
                    end else begin
                        miss_s      = 1'b1;
                        state_nxt_s = REFILL;
                    end
                end else begin
                    hit_s = 1'b0;
                end
            end
            REFILL: begin
                if (rdy_in && bus.mem_valid) begin
                    fill_word_s = 1'b1;
                    if (cnt_r == LAST_WORD) begin
                        fill_last_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        fill_last_s = 1'b0;
                    end
                end else begin
                    fill_word_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Refill bookkeeping and the registered memory request; the next address appears the cycle after each word.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_r        <= {WORD_BITS{1'b0}};
            refill_tag_r <= {TAG_W{1'b0}};
            refill_idx_r <= {INDEX_BITS{1'b0}};
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'd0;
        end else if (miss_s) begin
            cnt_r        <= {WORD_BITS{1'b0}};
            refill_tag_r <= pc_tag_s;
            refill_idx_r <= pc_idx_s;
            mem_req_r    <= 1'b1;
            mem_addr_r   <= {pc_tag_s, pc_idx_s, {WORD_BITS{1'b0}}, 2'b00};
        end else if (fill_last_s) begin
            cnt_r     <= {WORD_BITS{1'b0}};
            mem_req_r <= 1'b0;
        end else if (fill_word_s) begin
            cnt_r      <= cnt_r + WORD_BITS'(1'b1);
            mem_addr_r <= {refill_tag_r, refill_idx_r, cnt_r + WORD_BITS'(1'b1), 2'b00};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.inst_valid = hit_s;
    assign bus.inst_data  = hit_s ? rd_data_s : 32'd0;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_addr   = mem_addr_r;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed corner sequences, a vector table
// and randomized traffic checked against a line-level reference model.
module tb_inst_cache;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    inst_cache_if bus ();

    inst_cache dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;

    // stimulus state
    logic [31:0] pc;
    logic        fetch;
    logic        rdy;
    int          mem_lat;
    int          mem_wait;

    // observations of the last cycle
    logic        obs_valid, obs_req, obs_mv;
    logic [31:0] obs_data, obs_addr;

    // reference model: line storage plus the list of outstanding refill addresses
    logic        ref_valid [16];
    logic [23:0] ref_tag   [16];
    logic [31:0] ref_data  [16][4];
    logic [31:0] ref_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        fetch;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_0013;
        else if (a == 32'h0000_0004) return 32'h0010_0093;
        else return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_q.delete();
        mem_wait = 0;
    endtask

    // One clock cycle: memory responder, input drive, full model comparison, model update.
    task automatic cycle();
        logic        busy, hit;
        int          idx, wd, fidx, fwd;
        logic [23:0] tg;
        logic [31:0] exp_d, fa;
        bus.mem_valid = 1'b0;
        bus.mem_data  = 32'd0;
        if (rdy && bus.mem_req) begin
            if (mem_wait + 1 >= mem_lat) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = mem_word(bus.mem_addr);
                mem_wait      = 0;
            end else begin
                mem_wait++;
            end
        end
        bus.current_PC = pc;
        bus.fetch_inst = fetch;
        rdy_in         = rdy;
        #2;
        idx   = int'((pc / 32'd16) % 32'd16);
        wd    = int'((pc / 32'd4) % 32'd4);
        tg    = 24'(pc / 32'd256);
        busy  = (ref_q.size() != 0);
        hit   = rdy && !busy && fetch && ref_valid[idx] && (ref_tag[idx] == tg);
        exp_d = hit ? ref_data[idx][wd] : 32'd0;
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, hit});
        chk("inst_data", bus.inst_data, exp_d);
        chk("mem_req", {31'd0, bus.mem_req}, {31'd0, busy});
        if (busy) chk("mem_addr", bus.mem_addr, ref_q[0]);
        obs_valid = bus.inst_valid;
        obs_data  = bus.inst_data;
        obs_req   = bus.mem_req;
        obs_addr  = bus.mem_addr;
        obs_mv    = bus.mem_valid;
        if (rdy) begin
            if (busy) begin
                if (bus.mem_valid) begin
                    fa   = ref_q.pop_front();
                    fidx = int'((fa / 32'd16) % 32'd16);
                    fwd  = int'((fa / 32'd4) % 32'd4);
                    ref_data[fidx][fwd] = bus.mem_data;
                    if (ref_q.size() == 0) begin
                        ref_valid[fidx] = 1'b1;
                        ref_tag[fidx]   = 24'(fa / 32'd256);
                    end
                end
            end else if (fetch && !hit) begin
                ref_valid[idx] = 1'b0;
                for (int k = 0; k < 4; k++) ref_q.push_back((pc / 32'd16) * 32'd16 + 32'(4 * k));
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    // Run until the fetch hits; check the refill addresses from word 'first' and the one-cycle hit gap.
    task automatic fill_until_hit(input logic [31:0] base, input int first,
                                  input logic [31:0] exp_data, input string nm);
        logic [31:0] got[$];
        int last_mv, hit_at;
        last_mv = -1;
        hit_at  = -1;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (obs_mv) begin
                got.push_back(obs_addr);
                last_mv = c;
            end
            if (obs_valid) begin
                hit_at = c;
                break;
            end
        end
        chk({nm, "_words"}, got.size(), 32'(4 - first));
        for (int k = 0; k < got.size() && k < 4 - first; k++)
            chk({nm, "_addr"}, got[k], base + 32'(4 * (first + k)));
        chk({nm, "_hit_gap"}, 32'(hit_at - last_mv), 32'd1);
        chk({nm, "_data"}, obs_data, exp_data);
    endtask

    task automatic wait_first_word(input string nm);
        int seen;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            cycle();
            if (obs_mv) begin
                seen = 1;
                break;
            end
        end
        chk({nm, "_first_word"}, 32'(seen), 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0013};
        vecs[1] = '{32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h0010_0093};
        vecs[2] = '{32'h0000_0008, 1'b1, 1'b1, 1'b1, mem_word(32'h8)};
        vecs[3] = '{32'h0000_000C, 1'b1, 1'b1, 1'b1, mem_word(32'hC)};
        vecs[4] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_0013};
        vecs[7] = '{32'h0000_000E, 1'b1, 1'b1, 1'b1, mem_word(32'hC)};

        // reset state
        rst_in = 1'b1; rdy_in = 1'b1; rdy = 1'b1; fetch = 1'b0; pc = 32'd0; mem_lat = 3;
        bus.fetch_inst = 1'b0; bus.current_PC = 32'd0; bus.mem_valid = 1'b0; bus.mem_data = 32'd0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        rst_in = 1'b0;
        cycle();

        // cold miss, 3-cycle memory latency
        pc = 32'h0; fetch = 1'b1; mem_lat = 3;
        fill_until_hit(32'h0, 0, 32'h0000_0013, "cold");

        // hit stream and other single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            pc = vecs[i].pc; fetch = vecs[i].fetch; rdy = vecs[i].rdy;
            cycle();
            chk("tbl_valid", {31'd0, obs_valid}, {31'd0, vecs[i].exp_valid});
            chk("tbl_data", obs_data, vecs[i].exp_data);
            chk("tbl_req", {31'd0, obs_req}, 32'd0);
        end
        rdy = 1'b1;

        // conflict eviction on index 0
        pc = 32'h100; fetch = 1'b1; mem_lat = 2;
        fill_until_hit(32'h100, 0, mem_word(32'h100), "conflict");
        pc = 32'h0;
        cycle();
        chk("conflict_remiss", {31'd0, obs_valid}, 32'd0);
        fill_until_hit(32'h0, 0, 32'h0000_0013, "refill0");

        // redirect to a resident line after the second word
        begin
            logic [31:0] got[$];
            pc = 32'h40; fetch = 1'b1; mem_lat = 2;
            for (int c = 0; c < 100 && got.size() < 4; c++) begin
                cycle();
                if (obs_mv) begin
                    got.push_back(obs_addr);
                    if (got.size() == 2) pc = 32'h0;
                end
            end
            chk("redir_words", got.size(), 32'd4);
            if (got.size() == 4) begin
                chk("redir_addr2", got[2], 32'h48);
                chk("redir_addr3", got[3], 32'h4C);
            end
            cycle();
            chk("redir_hit", {31'd0, obs_valid}, 32'd1);
            chk("redir_data", obs_data, 32'h0000_0013);
            pc = 32'h40;
            cycle();
            chk("redir_line40", {31'd0, obs_valid}, 32'd1);
            chk("redir_data40", obs_data, mem_word(32'h40));
        end

        // rdy_in low for 5 cycles during a refill
        pc = 32'h80; fetch = 1'b1; mem_lat = 2;
        wait_first_word("pause");
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("pause_req", {31'd0, obs_req}, 32'd1);
            chk("pause_addr", obs_addr, 32'h84);
            chk("pause_valid", {31'd0, obs_valid}, 32'd0);
        end
        rdy = 1'b1;
        fill_until_hit(32'h80, 1, mem_word(32'h80), "resume");

        // asynchronous reset between edges in the middle of a refill
        pc = 32'hC0; fetch = 1'b1; mem_lat = 2;
        wait_first_word("arst");
        bus.mem_valid = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("arst_addr", bus.mem_addr, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cycle();
        chk("arst_remiss", {31'd0, obs_valid}, 32'd0);
        fill_until_hit(32'hC0, 0, mem_word(32'hC0), "arst_refill");

        // randomized traffic with redirects, pauses and varying latency
        for (int c = 0; c < 600; c++) begin
            if (ref_q.size() == 0) mem_lat = int'($urandom_range(4, 1));
            pc    = ($urandom_range(2, 0) << 8) | ($urandom_range(15, 0) << 4) | $urandom_range(15, 0);
            fetch = ($urandom_range(3, 0) != 0);
            rdy   = ($urandom_range(7, 0) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
